// File: rtl/mux_4to1_rr_stream_if.sv
// Valid/ready bundle for the 4-lane round-robin stream merger: four input lanes, one merged output.
interface mux_4to1_rr_stream_if #(
  parameter int width = 32
) ();
  logic [width-1:0] i0, i1, i2, i3;
  logic             i0_valid, i1_valid, i2_valid, i3_valid;
  logic             i0_ready, i1_ready, i2_ready, i3_ready;
  logic [width-1:0] o;
  logic [1:0]       o_sel;
  logic             o_valid;
  logic             o_ready;

  // Producer lanes and downstream consumer side.
  modport master (
    output i0, i1, i2, i3, i0_valid, i1_valid, i2_valid, i3_valid, o_ready,
    input  i0_ready, i1_ready, i2_ready, i3_ready, o, o_sel, o_valid
  );

  // The merger itself.
  modport slave (
    input  i0, i1, i2, i3, i0_valid, i1_valid, i2_valid, i3_valid, o_ready,
    output i0_ready, i1_ready, i2_ready, i3_ready, o, o_sel, o_valid
  );
endinterface

// File: rtl/mux_4to1_rr_stream.sv
// Merges four valid/ready lanes into one stream: per-beat round-robin grant feeding a
// one-deep registered output slice (full throughput, no valid->output combinational path).
module mux_4to1_rr_stream #(
  parameter int width = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  mux_4to1_rr_stream_if.slave     bus
);

  logic [width-1:0] w_data [4];
  logic [3:0]       w_valid;
  logic [3:0]       w_ready;
  logic [1:0]       w_grant;
  logic             w_any_req;
  logic             w_load_en;

  logic [1:0]       r_last;
  logic [width-1:0] r_o;
  logic [1:0]       r_o_sel;
  logic             r_o_valid;

  assign w_data[0] = bus.i0;
  assign w_data[1] = bus.i1;
  assign w_data[2] = bus.i2;
  assign w_data[3] = bus.i3;
  assign w_valid   = {bus.i3_valid, bus.i2_valid, bus.i1_valid, bus.i0_valid};

  // First valid lane searching last+1 .. last+4, wrapping on the 2-bit index.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] valid);
    logic [1:0] idx;
    logic       found;
    rr_pick = 2'd0;
    found   = 1'b0;
    idx     = last;
    for (int k = 0; k < 4; k++) begin
      idx = idx + 2'd1;
      if (!found && valid[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb w_grant = rr_pick(r_last, w_valid);

  assign w_any_req = |w_valid;
  assign w_load_en = !r_o_valid || bus.o_ready;

  // NOTE: default every always_comb output first so no latch is inferred.
  always_comb begin
    w_ready = '0;
    if (!rst && w_load_en && w_any_req) w_ready[w_grant] = 1'b1;
  end

  assign bus.i0_ready = w_ready[0];
  assign bus.i1_ready = w_ready[1];
  assign bus.i2_ready = w_ready[2];
  assign bus.i3_ready = w_ready[3];

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data register is reset too, so o reads 0 right after reset.
      r_o       <= '0;
      r_o_sel   <= 2'b00;
      r_o_valid <= 1'b0;
      r_last    <= 2'b11;
    end else if (w_load_en) begin
      if (w_any_req) begin
        r_o       <= w_data[w_grant];
        r_o_sel   <= w_grant;
        r_o_valid <= 1'b1;
        r_last    <= w_grant;
      end else begin
        r_o_valid <= 1'b0;
      end
    end
  end

  assign bus.o       = r_o;
  assign bus.o_sel   = r_o_sel;
  assign bus.o_valid = r_o_valid;

endmodule

// File: tb/tb_mux_4to1_rr_stream.sv
// Self-checking bench for mux_4to1_rr_stream: table vectors, hand-written corner sequences,
// and a beat scoreboard filled on input accepts and drained on output transfers.
module tb_mux_4to1_rr_stream;

  localparam int W = 32;

  typedef struct {
    logic [1:0]   lane;
    logic [W-1:0] data;
  } beat_t;

  typedef struct {
    logic [3:0] valid;
    logic       o_ready;
    logic [3:0] exp_ready;
    logic       exp_ov;
    logic [1:0] exp_sel;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_4to1_rr_stream_if #(.width(W)) bus ();
  mux_4to1_rr_stream #(.width(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [W-1:0] tb_data [4];
  logic [3:0]   tb_valid;
  logic         tb_o_ready;

  assign bus.i0 = tb_data[0];
  assign bus.i1 = tb_data[1];
  assign bus.i2 = tb_data[2];
  assign bus.i3 = tb_data[3];
  assign {bus.i3_valid, bus.i2_valid, bus.i1_valid, bus.i0_valid} = tb_valid;
  assign bus.o_ready = tb_o_ready;

  // Reference model of the output slice and pointer.
  logic [1:0]   m_last;
  logic         m_valid;
  logic [W-1:0] m_o;
  logic [1:0]   m_sel;

  beat_t        sb [$];
  int           lane_pops [4];
  int           n_cmp  = 0;
  int           n_fail = 0;

  logic [3:0]   s_ready;
  logic         s_acc;
  logic [1:0]   s_lane;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [1:0] model_grant(input logic [1:0] last, input logic [3:0] valid);
    for (int k = 1; k <= 4; k++) begin
      int l;
      l = (int'(last) + k) % 4;
      if (valid[l]) return 2'(l);
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_last  = 2'b11;
    m_valid = 1'b0;
    m_o     = '0;
    m_sel   = 2'b00;
    sb.delete();
    for (int l = 0; l < 4; l++) lane_pops[l] = 0;
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge, return at +1.
  task automatic step();
    logic       load, any;
    logic [1:0] g;
    logic [3:0] exp_rdy;
    beat_t      b;
    @(negedge clk);
    any     = |tb_valid;
    load    = !m_valid || tb_o_ready;
    g       = model_grant(m_last, tb_valid);
    exp_rdy = (load && any) ? (4'b0001 << g) : 4'b0000;
    s_ready = {bus.i3_ready, bus.i2_ready, bus.i1_ready, bus.i0_ready};
    check("ready", 64'(s_ready), 64'(exp_rdy));
    check("o_valid", 64'(bus.o_valid), 64'(m_valid));
    if (bus.o_valid && tb_o_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_underflow: got beat %0h with no pending expected beat", bus.o);
      end else begin
        b = sb.pop_front();
        check("sb_data", 64'(bus.o), 64'(b.data));
        check("sb_sel", 64'(bus.o_sel), 64'(b.lane));
        lane_pops[b.lane]++;
      end
    end
    s_acc  = load && any;
    s_lane = g;
    if (s_acc) sb.push_back('{lane: g, data: tb_data[g]});
    @(posedge clk);
    if (load && any) begin
      m_o     = tb_data[g];
      m_sel   = g;
      m_valid = 1'b1;
      m_last  = g;
    end else if (load) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    tb_valid   = 4'b0000;
    tb_o_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", 64'(bus.o_valid), 64'd0);
    check("rst_o", 64'(bus.o), 64'd0);
    check("rst_o_sel", 64'(bus.o_sel), 64'd0);
    rst = 1'b0;
    model_reset();
  endtask

  vec_t vt [13];
  int   cnt [4];

  initial begin
    for (int l = 0; l < 4; l++) tb_data[l] = 32'h1000_0000 | W'(l);
    tb_valid   = 4'b0000;
    tb_o_ready = 1'b0;
    model_reset();

    // Fairness (0..5) then stall with lanes 0 and 3 (6..12); each block starts from reset.
    vt[0]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
    vt[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
    vt[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
    vt[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3};
    vt[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
    vt[5]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
    vt[6]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
    vt[7]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd0};
    vt[8]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd0};
    vt[9]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd0};
    vt[10] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
    vt[11] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
    vt[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

    for (int i = 0; i < 13; i++) begin
      if (i == 0 || i == 6) do_reset();
      tb_valid   = vt[i].valid;
      tb_o_ready = vt[i].o_ready;
      step();
      check($sformatf("vec%0d_ready", i), 64'(s_ready), 64'(vt[i].exp_ready));
      check($sformatf("vec%0d_o_valid", i), 64'(bus.o_valid), 64'(vt[i].exp_ov));
      if (vt[i].exp_ov) begin
        check($sformatf("vec%0d_o_sel", i), 64'(bus.o_sel), 64'(vt[i].exp_sel));
        check($sformatf("vec%0d_o", i), 64'(bus.o), 64'(32'h1000_0000 | W'(vt[i].exp_sel)));
      end
    end

    // Single beat on lane 2, then the slice empties.
    do_reset();
    tb_data[2] = 32'hCAFE_0002;
    tb_valid   = 4'b0100;
    tb_o_ready = 1'b1;
    step();
    check("t1_ready", 64'(s_ready), 64'b0100);
    check("t1_o", 64'(bus.o), 64'h0000_0000_CAFE_0002);
    check("t1_o_sel", 64'(bus.o_sel), 64'd2);
    check("t1_o_valid", 64'(bus.o_valid), 64'd1);
    tb_valid = 4'b0000;
    step();
    check("t1_o_valid_drop", 64'(bus.o_valid), 64'd0);

    // Lane 1 alone streams five back-to-back beats.
    do_reset();
    tb_o_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tb_data[1] = W'(k);
      tb_valid   = 4'b0010;
      step();
      check($sformatf("t4_o_%0d", k), 64'(bus.o), 64'(k));
      check($sformatf("t4_sel_%0d", k), 64'(bus.o_sel), 64'd1);
      check($sformatf("t4_valid_%0d", k), 64'(bus.o_valid), 64'd1);
    end
    tb_valid = 4'b0000;
    step();

    // Asynchronous reset while a beat is stalled in the slice.
    do_reset();
    tb_data[2] = 32'h5555_0002;
    tb_valid   = 4'b0100;
    tb_o_ready = 1'b1;
    step();
    tb_o_ready = 1'b0;
    step();
    check("t5_stalled_valid", 64'(bus.o_valid), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check("t5_async_o_valid", 64'(bus.o_valid), 64'd0);
    check("t5_async_o", 64'(bus.o), 64'd0);
    check("t5_async_o_sel", 64'(bus.o_sel), 64'd0);
    check("t5_async_ready", 64'({bus.i3_ready, bus.i2_ready, bus.i1_ready, bus.i0_ready}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tb_data[0] = 32'h1000_0000;
    tb_data[1] = 32'h1000_0001;
    tb_valid   = 4'b0011;
    tb_o_ready = 1'b1;
    step();
    check("t5_first_grant", 64'(s_ready), 64'b0001);
    check("t5_o_sel", 64'(bus.o_sel), 64'd0);
    check("t5_o", 64'(bus.o), 64'h0000_0000_1000_0000);

    // All lanes valid, o_ready toggling: every beat leaves exactly once.
    do_reset();
    for (int l = 0; l < 4; l++) begin
      cnt[l]     = 0;
      tb_data[l] = 32'h6000_0000 | (W'(l) << 8);
    end
    tb_valid = 4'hF;
    for (int c = 0; c < 16; c++) begin
      tb_o_ready = (c % 2 == 0);
      step();
      if (s_acc) begin
        cnt[s_lane]++;
        tb_data[s_lane] = 32'h6000_0000 | (W'(s_lane) << 8) | W'(cnt[s_lane]);
      end
    end
    tb_valid   = 4'b0000;
    tb_o_ready = 1'b1;
    repeat (3) step();
    for (int l = 0; l < 4; l++) check($sformatf("t6_lane%0d_beats", l), 64'(lane_pops[l]), 64'd2);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
